// File: rtl/vc_arb_pkg.sv
// vc_arbiter shared definitions: FSM encodings and default weight width.
// Optional per-VC grant statistics are enabled with VC_ARB_STATS_EN.
package vc_arb_pkg;

  localparam int WEIGHT_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wrr_credit_ctr.sv
// Weighted round-robin credit tracking for two VCs:
// current owner, consecutive-grant credit and latched weights.
module wrr_credit_ctr
  import vc_arb_pkg::*;
#(
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                grant_own,
  input  logic                grant_oth,
  input  logic [WEIGHT_W-1:0] vc0_weight,
  input  logic [WEIGHT_W-1:0] vc1_weight,
  output logic                owner,
  output logic [WEIGHT_W-1:0] credit,
  output logic                below_weight
);

  localparam logic [WEIGHT_W-1:0] ONE  = WEIGHT_W'(1);
  localparam logic [WEIGHT_W-1:0] CMAX = '1;

  logic [WEIGHT_W-1:0] w0_q;
  logic [WEIGHT_W-1:0] w1_q;

  // Zero weights are stored as one so the compare below never starves.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= 1'b0;
      credit <= '0;
      w0_q   <= ONE;
      w1_q   <= ONE;
    end else if (load) begin
      owner  <= 1'b0;
      credit <= '0;
      w0_q   <= (vc0_weight == '0) ? ONE : vc0_weight;
      w1_q   <= (vc1_weight == '0) ? ONE : vc1_weight;
    end else if (grant_own) begin
      if (credit != CMAX)
        credit <= credit + ONE;
    end else if (grant_oth) begin
      owner  <= ~owner;
      credit <= ONE;
    end
  end

  assign below_weight = credit < (owner ? w1_q : w0_q);

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC weighted round-robin arbiter with destination back-pressure.
// Define VC_ARB_STATS_EN to add 8-bit per-VC grant counters.
module vc_arbiter
  import vc_arb_pkg::*;
#(
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] vc0_weight,
  input  logic [WEIGHT_W-1:0] vc1_weight,
  input  logic                vc0_empty,
  input  logic                vc1_empty,
  input  logic                vc0_head_dest,
  input  logic                vc1_head_dest,
  input  logic                dest0_almost_full,
  input  logic                dest1_almost_full,
  output logic                pop_vc0,
  output logic                pop_vc1,
  output logic                owner,
`ifdef VC_ARB_STATS_EN
  output logic [7:0]          grant_cnt0,
  output logic [7:0]          grant_cnt1,
`endif
  output logic [1:0]          state
);

  arb_state_e          st_q;
  arb_state_e          st_nxt;
  logic [WEIGHT_W-1:0] credit;
  logic                below;
  logic                elig0;
  logic                elig1;
  logic                own_elig;
  logic                oth_elig;
  logic                can_pop;
  logic                grant_own;
  logic                grant_oth;
  logic                any_pop;

  assign elig0 = !vc0_empty &&
    !(vc0_head_dest ? dest1_almost_full : dest0_almost_full);
  assign elig1 = !vc1_empty &&
    !(vc1_head_dest ? dest1_almost_full : dest0_almost_full);

  // Reset and init gate pops in the same cycle they are seen.
  assign can_pop = !reset && !init &&
    (st_q == ST_IDLE || st_q == ST_ACTIVE);

  assign own_elig = owner ? elig1 : elig0;
  assign oth_elig = owner ? elig0 : elig1;

  assign grant_own = can_pop && own_elig && (below || !oth_elig);
  assign grant_oth = can_pop && oth_elig && !(own_elig && below);
  assign any_pop   = grant_own || grant_oth;

  assign pop_vc0 = owner ? grant_oth : grant_own;
  assign pop_vc1 = owner ? grant_own : grant_oth;

  always_comb begin
    st_nxt = st_q;
    unique case (st_q)
      ST_RESET:  st_nxt = ST_INIT;
      ST_INIT:   st_nxt = init ? ST_INIT : ST_IDLE;
      ST_IDLE,
      ST_ACTIVE: begin
        if (init)
          st_nxt = ST_INIT;
        else
          st_nxt = any_pop ? ST_ACTIVE : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      st_q <= ST_RESET;
    else
      st_q <= st_nxt;
  end

  assign state = st_q;

  wrr_credit_ctr #(
    .WEIGHT_W (WEIGHT_W)
  ) u_ctr (
    .clk          (clk),
    .reset        (reset),
    .load         (st_q == ST_INIT),
    .grant_own    (grant_own),
    .grant_oth    (grant_oth),
    .vc0_weight   (vc0_weight),
    .vc1_weight   (vc1_weight),
    .owner        (owner),
    .credit       (credit),
    .below_weight (below)
  );

`ifdef VC_ARB_STATS_EN
  logic enter_init;

  assign enter_init = (st_nxt == ST_INIT) && (st_q != ST_INIT);

  always_ff @(posedge clk) begin
    if (reset || enter_init) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (pop_vc0)
        grant_cnt0 <= grant_cnt0 + 8'd1;
      if (pop_vc1)
        grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule
